division_product_checker: RTL and testbench

- Sequential shift-add multiply-accumulate: the inverse of the non-restoring divider.
- Reconstructs result = quotient*divisor + remainder from the divider's outputs.
- Compares the result against the original dividend and flags a match.
- Sits downstream of non_restoring_division_topmodule as a self-check and recombination unit. Uses the same start/done handshake style.

---
 rtl/division_product_checker.sv | 107 ++++++++++
 tb/tb_division_product_checker.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/division_product_checker.sv
// Shift-add recombination of divider outputs: result = quotient*divisor + remainder,
// with a match flag against the original dividend.
module division_product_checker #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH:0]     remainder,
  input  logic [WIDTH-1:0]   dividend,
  output logic [2*WIDTH:0]   result,
  output logic               match,
  output logic               busy,
  output logic               done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_ADD  = 2'd2;

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [2*WIDTH-1:0] r_acc;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH:0]   r_result;
  logic               r_match;
  logic               r_busy;
  logic               r_done;

  logic [2*WIDTH-1:0] w_addend;
  logic [2*WIDTH:0]   w_sum;
  logic               w_match;
  logic               w_last;

  assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
  // Remainder is signed; sign-extend it into the full-width sum.
  assign w_sum    = {1'b0, r_acc}
                  + {{WIDTH{r_rem[WIDTH]}}, r_rem};
  assign w_match  = (w_sum == {{(WIDTH+1){1'b0}}, r_dvd});
  assign w_last   = (r_cnt == CW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_match  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_mcand  <= quotient;
            r_mplier <= divisor;
            r_rem    <= remainder;
            r_dvd    <= dividend;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_MUL;
          end
        end
        S_MUL: begin
          if (r_mplier[0]) begin
            r_acc <= r_acc + w_addend;
          end
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_result <= w_sum;
          r_match  <= w_match;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign result = r_result;
  assign match  = r_match;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_division_product_checker.sv
// Scoreboard bench for division_product_checker: driver pushes expected
// outcomes computed arithmetically, monitor pops them on each done pulse.
module tb_division_product_checker;

  localparam int W   = 16;
  localparam int LAT = W + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  quotient;
  logic [W-1:0]  divisor;
  logic [W:0]    remainder;
  logic [W-1:0]  dividend;
  logic [2*W:0]  result;
  logic          match;
  logic          busy;
  logic          done;

  division_product_checker #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .dividend  (dividend),
    .result    (result),
    .match     (match),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    logic [2*W:0] res;
    logic         m;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   busy_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act,
                       input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the signed remainder.
  function automatic exp_t model(input logic [W-1:0] q,
                                 input logic [W-1:0] d,
                                 input logic [W:0]   r,
                                 input logic [W-1:0] dv);
    exp_t   e;
    longint sr;
    longint v;
    sr = r[W] ? longint'(r) - (longint'(1) << (W+1)) : longint'(r);
    v  = longint'(q) * longint'(d) + sr;
    e.res = v[2*W:0];
    e.m   = (v == longint'(dv));
    e.acc = 0;
    return e;
  endfunction

  // Called at a negedge while the DUT is idle.
  task automatic issue(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W:0] r, input logic [W-1:0] dv);
    exp_t e;
    e = model(q, d, r, dv);
    e.acc = cyc + 1;
    sb.push_back(e);
    quotient  = q;
    divisor   = d;
    remainder = r;
    dividend  = dv;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    quotient  = W'($urandom);
    divisor   = W'($urandom);
    remainder = (W+1)'($urandom);
    dividend  = W'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("wait_idle_timeout", 1, 0);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("match", match, e.m);
          check("latency", cyc - e.acc, LAT);
          check("busy_cycles", busy_cnt, LAT);
          check("busy_at_done", busy, 0);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] q, d, dv;
    logic [W:0]   r;
    longint       v;
    rst = 1'b0; start = 1'b0;
    quotient = '0; divisor = '0; remainder = '0; dividend = '0;
    repeat (2) @(negedge clk);
    check("rst_result", result, 0);
    check("rst_match", match, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    @(negedge clk);

    issue(16'd459, 16'd7, 17'd6, 16'd3219);
    wait_idle();
    // start in the done cycle
    issue(16'd3, 16'd2, 17'd1, 16'd7);
    wait_idle();
    issue(16'd1, 16'd15, 17'd0, 16'd15);
    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_result", result, 15);
    check("hold_match", match, 1);

    issue(16'hFFFF, 16'hFFFF, 17'h0FFFE, 16'd5);
    wait_idle();
    issue(16'd0, 16'd0, 17'h1FFFD, 16'd0);
    wait_idle();

    issue(16'd1, 16'd2017, 17'd1202, 16'd3219);
    repeat (3) @(negedge clk);
    quotient = 16'd9; divisor = 16'd9;
    remainder = 17'd0; dividend = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    issue(16'd100, 16'd100, 17'd5, 16'd10005);
    repeat (6) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    check("midrst_busy", busy, 0);
    check("midrst_result", result, 0);
    check("midrst_match", match, 0);
    repeat (25) @(negedge clk);

    issue(16'd123, 16'd45, 17'd44, 16'd5579);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      q = W'($urandom);
      d = W'($urandom);
      r = (W+1)'($urandom);
      if (i % 4 == 0) d = '0;
      dv = W'($urandom);
      if (i % 2 == 0) begin
        q = W'($urandom_range(0, 255));
        d = W'($urandom_range(0, 255));
        r = (W+1)'($urandom_range(0, 255));
        v = longint'(q) * longint'(d) + longint'(r);
        dv = v[W-1:0];
      end
      issue(q, d, r, dv);
      wait_idle();
    end

    repeat (25) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
